// File: rtl/video_timing_gen.sv
// Video timing generator with genlock: pixel-enable divider, sync/DE/beam position, gated RGB pass-through.
// Sync/DE/RGB registered one pixel after o_x/o_y issue that position; free-running, no backpressure.
module video_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACT       = 1280,
    parameter int H_FP        = 8,
    parameter int H_SYNC      = 32,
    parameter int H_BP        = 38,
    parameter int V_ACT       = 720,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 7,
    parameter int V_BP        = 9,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter bit DE_POL      = 1'b1,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    input  logic        i_frame_end,
    input  logic        i_genlock_en,
    output logic        o_pix_ce,
    output logic        o_adv_clk,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_adv_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame,
    output logic        o_locked
);
    localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int CW = $clog2(LOCK_FRAMES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_FRAMES);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_q;
    logic          de_q, hs_q, vs_q;
    logic [11:0]   x_q, y_q;
    logic [7:0]    r_q, g_q, b_q;

    logic pix_ce, line_end, v_last, consume;
    logic act_cur, act_nxt, hs_cur, vs_cur;

    assign pix_ce   = (div_q == DIV_LAST);
    assign line_end = pix_ce && (h_q == H_LAST);
    assign v_last   = (v_q == V_LAST);
    // Pending is only honoured while genlock is still enabled on the consuming cycle.
    assign consume  = pend_q && i_genlock_en;

    assign act_cur = (int'(h_q) < H_ACT) && (int'(v_q) < V_ACT);
    assign act_nxt = (int'(h_d) < H_ACT) && (int'(v_d) < V_ACT);
    assign hs_cur  = (int'(h_q) >= H_ACT + H_FP) && (int'(h_q) < H_ACT + H_FP + H_SYNC);
    assign vs_cur  = (int'(v_q) >= V_ACT + V_FP) && (int'(v_q) < V_ACT + V_FP + V_SYNC);

    always_comb begin
        div_d  = pix_ce ? '0 : div_q + DW'(1);
        h_d    = h_q;
        v_d    = v_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (pix_ce) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + HW'(1);
        end
        if (line_end) begin
            if (consume) begin
                v_d    = '0;
                pend_d = 1'b0;
                if (int'(v_q) >= VT - 1 - LOCK_TOL) begin
                    cnt_d = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end else begin
                v_d = v_last ? '0 : v_q + VW'(1);
                if (v_last) begin
                    cnt_d = '0;
                end
            end
        end
        // A pulse landing on the consuming edge re-arms for the following line end.
        if (i_frame_end) begin
            pend_d = 1'b1;
        end
        if (!i_genlock_en) begin
            pend_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            lock_q <= (cnt_d == LOCK_MAX);
            if (pix_ce) begin
                de_q <= act_cur;
                hs_q <= hs_cur;
                vs_q <= vs_cur;
                x_q  <= act_nxt ? 12'(h_d) : '0;
                y_q  <= act_nxt ? 12'(v_d) : '0;
                r_q  <= act_cur ? i_r : '0;
                g_q  <= act_cur ? i_g : '0;
                b_q  <= act_cur ? i_b : '0;
            end
        end
    end

    assign o_pix_ce  = pix_ce;
    assign o_adv_clk = (div_q >= DIV_HALF);
    assign o_hsync   = hs_q ~^ HS_POL;
    assign o_vsync   = vs_q ~^ VS_POL;
    assign o_adv_de  = de_q ~^ DE_POL;
    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_r       = r_q;
    assign o_g       = g_q;
    assign o_b       = b_q;
    assign o_frame   = line_end && (consume || v_last);
    assign o_locked  = lock_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: small raster (HT=15, VT=8, CLK_DIV=2), positive and inverted polarity instances.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] i_r = '0, i_g = '0, i_b = '0;
    logic i_frame_end = 1'b0;
    logic i_genlock_en = 1'b0;

    logic a_ce, a_aclk, a_hs, a_vs, a_de, a_fr, a_lk;
    logic [11:0] a_x, a_y;
    logic [7:0] a_r, a_g, a_b;
    logic b_ce, b_aclk, b_hs, b_vs, b_de, b_fr, b_lk;
    logic [11:0] b_x, b_y;
    logic [7:0] b_r, b_g, b_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CLK_DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DE_POL(1'b1), .LOCK_TOL(1), .LOCK_FRAMES(3)
    ) dut_a (
        .clk(clk), .reset(reset), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_frame_end(i_frame_end), .i_genlock_en(i_genlock_en),
        .o_pix_ce(a_ce), .o_adv_clk(a_aclk), .o_hsync(a_hs), .o_vsync(a_vs), .o_adv_de(a_de),
        .o_x(a_x), .o_y(a_y), .o_r(a_r), .o_g(a_g), .o_b(a_b), .o_frame(a_fr), .o_locked(a_lk)
    );

    video_timing_gen #(
        .CLK_DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b0), .LOCK_TOL(1), .LOCK_FRAMES(3)
    ) dut_b (
        .clk(clk), .reset(reset), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_frame_end(i_frame_end), .i_genlock_en(i_genlock_en),
        .o_pix_ce(b_ce), .o_adv_clk(b_aclk), .o_hsync(b_hs), .o_vsync(b_vs), .o_adv_de(b_de),
        .o_x(b_x), .o_y(b_y), .o_r(b_r), .o_g(b_g), .o_b(b_b), .o_frame(b_fr), .o_locked(b_lk)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return, the next rising edge is edge 1 of the new run.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_ce, a_aclk, a_hs, a_vs, a_de, a_fr, a_lk} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got ce/aclk/hs/vs/de/fr/lk=%b want 0000000",
                     {a_ce, a_aclk, a_hs, a_vs, a_de, a_fr, a_lk});
        end
        checks++;
        if ({a_x, a_y, a_r, a_g, a_b} !== 48'h0) begin
            errors++;
            $display("FAIL reset_dat got x=%0d y=%0d rgb=%h%h%h want all 0", a_x, a_y, a_r, a_g, a_b);
        end
        checks++;
        if ({b_hs, b_vs, b_de} !== 3'b111) begin
            errors++;
            $display("FAIL reset_inv_pol got hs/vs/de=%b want 111", {b_hs, b_vs, b_de});
        end
    endtask

    // Full free-running timing over two frames, genlock off (one ignored frame-end pulse).
    task automatic test_timing();
        int p, q, hq, lq, hc, lc;
        int bad_ce, bad_de, bad_hs, bad_vs, bad_xy, bad_rgb, bad_fr, bad_inv;
        int frames, de_cnt, first_fr;
        logic e_de, e_hs, e_vs, e_fr, e_act;
        bad_ce = 0; bad_de = 0; bad_hs = 0; bad_vs = 0; bad_xy = 0;
        bad_rgb = 0; bad_fr = 0; bad_inv = 0; frames = 0; de_cnt = 0; first_fr = -1;
        i_r = 8'hAA; i_g = 8'h55; i_b = 8'h0F; i_genlock_en = 1'b0;
        do_reset();
        for (int e = 1; e <= 480; e++) begin
            tick();
            i_frame_end = (e == 50);
            p = e / 2;
            q = p - 1;
            hq = (q < 0) ? 99 : q % 15;
            lq = (q < 0) ? 99 : (q / 15) % 8;
            hc = p % 15;
            lc = (p / 15) % 8;
            e_de  = (hq < 8) && (lq < 4);
            e_hs  = (hq >= 10) && (hq <= 12);
            e_vs  = (lq == 5) || (lq == 6);
            e_act = (hc < 8) && (lc < 4);
            e_fr  = (e % 2 == 1) && (p % 120 == 119);
            if (a_ce !== (e % 2 == 1) || a_aclk !== (e % 2 == 1)) bad_ce++;
            if (a_de !== e_de) bad_de++;
            if (a_hs !== e_hs) bad_hs++;
            if (a_vs !== e_vs) bad_vs++;
            if (a_x !== (e_act ? 12'(hc) : 12'd0) || a_y !== (e_act ? 12'(lc) : 12'd0)) bad_xy++;
            if (a_r !== (e_de ? 8'hAA : 8'h00) || a_g !== (e_de ? 8'h55 : 8'h00)
                || a_b !== (e_de ? 8'h0F : 8'h00)) bad_rgb++;
            if (a_fr !== e_fr) bad_fr++;
            if (b_hs !== ~e_hs || b_vs !== ~e_vs || b_de !== ~e_de) bad_inv++;
            if (a_fr === 1'b1) begin
                frames++;
                if (first_fr < 0) first_fr = e;
            end
            if (e % 2 == 0 && a_de === 1'b1) de_cnt++;
        end
        i_frame_end = 1'b0;
        checks++; if (bad_ce != 0) begin errors++; $display("FAIL pix_ce_adv_clk bad=%0d want 0", bad_ce); end
        checks++; if (bad_de != 0) begin errors++; $display("FAIL de_window bad=%0d want 0", bad_de); end
        checks++; if (bad_hs != 0) begin errors++; $display("FAIL hsync_window bad=%0d want 0", bad_hs); end
        checks++; if (bad_vs != 0) begin errors++; $display("FAIL vsync_window bad=%0d want 0", bad_vs); end
        checks++; if (bad_xy != 0) begin errors++; $display("FAIL beam_xy bad=%0d want 0", bad_xy); end
        checks++; if (bad_rgb != 0) begin errors++; $display("FAIL rgb_gate bad=%0d want 0", bad_rgb); end
        checks++; if (bad_fr != 0) begin errors++; $display("FAIL frame_pulse bad=%0d want 0", bad_fr); end
        checks++; if (bad_inv != 0) begin errors++; $display("FAIL inverted_pol bad=%0d want 0", bad_inv); end
        checks++; if (frames != 2) begin errors++; $display("FAIL frame_count got %0d want 2", frames); end
        checks++; if (first_fr != 239) begin errors++; $display("FAIL first_frame_clk got %0d want 239", first_fr); end
        checks++; if (de_cnt != 64) begin errors++; $display("FAIL de_pixel_count got %0d want 64", de_cnt); end
    endtask

    // Resync far from natural frame end: early wrap, counted as a miss.
    task automatic test_genlock_miss();
        int early;
        early = 0;
        i_genlock_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 130; e++) begin
            tick();
            i_frame_end = (e == 70);
            if (e >= 71 && e <= 87 && a_fr === 1'b1) early++;
            if (e == 89) begin
                checks++;
                if (a_fr !== 1'b1) begin errors++; $display("FAIL resync_frame got %b want 1", a_fr); end
            end
            if (e == 90) begin
                checks++;
                if (a_x !== 12'd0 || a_y !== 12'd0) begin
                    errors++; $display("FAIL resync_xy got x=%0d y=%0d want 0,0", a_x, a_y);
                end
            end
            if (e == 120) begin
                checks++;
                if (a_y !== 12'd1) begin errors++; $display("FAIL resync_next_line got y=%0d want 1", a_y); end
            end
        end
        checks++; if (early != 0) begin errors++; $display("FAIL mid_line_jump got %0d want 0", early); end
        checks++; if (a_lk !== 1'b0) begin errors++; $display("FAIL miss_locked got %b want 0", a_lk); end
    endtask

    // Pulses in the last line of each frame; one omitted frame drops lock.
    task automatic test_lock();
        int frames;
        frames = 0;
        i_genlock_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 1240; e++) begin
            tick();
            i_frame_end = (e == 220) || (e == 460) || (e == 700) || (e == 1180);
            if (a_fr === 1'b1) frames++;
            if (e == 481) begin checks++; if (a_lk !== 1'b0) begin errors++; $display("FAIL lock_after2 got %b want 0", a_lk); end end
            if (e == 719) begin checks++; if (a_lk !== 1'b0) begin errors++; $display("FAIL lock_before3 got %b want 0", a_lk); end end
            if (e == 720) begin checks++; if (a_lk !== 1'b1) begin errors++; $display("FAIL lock_after3 got %b want 1", a_lk); end end
            if (e == 959) begin checks++; if (a_lk !== 1'b1) begin errors++; $display("FAIL lock_held got %b want 1", a_lk); end end
            if (e == 960) begin checks++; if (a_lk !== 1'b0) begin errors++; $display("FAIL lock_lost got %b want 0", a_lk); end end
            if (e == 1201) begin checks++; if (a_lk !== 1'b0) begin errors++; $display("FAIL lock_relearn got %b want 0", a_lk); end end
        end
        i_frame_end = 1'b0;
        checks++; if (frames != 5) begin errors++; $display("FAIL lock_frames got %0d want 5", frames); end
    endtask

    // Resync at line 6 is still inside the window (VT-1-LOCK_TOL) and shortens each frame.
    task automatic test_lock_window();
        int frames, first_fr;
        frames = 0; first_fr = -1;
        i_genlock_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 640; e++) begin
            tick();
            i_frame_end = (e == 190) || (e == 400) || (e == 610);
            if (a_fr === 1'b1) begin
                frames++;
                if (first_fr < 0) first_fr = e;
            end
            if (e == 629) begin checks++; if (a_lk !== 1'b0) begin errors++; $display("FAIL window_pre got %b want 0", a_lk); end end
            if (e == 630) begin checks++; if (a_lk !== 1'b1) begin errors++; $display("FAIL window_lock got %b want 1", a_lk); end end
        end
        i_frame_end = 1'b0;
        checks++; if (frames != 3) begin errors++; $display("FAIL window_frames got %0d want 3", frames); end
        checks++; if (first_fr != 209) begin errors++; $display("FAIL window_first got %0d want 209", first_fr); end
    endtask

    // Pulse on the consuming edge re-arms; disabling genlock drops a pending resync.
    task automatic test_back_to_back();
        i_genlock_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 90; e++) begin
            tick();
            i_frame_end = (e == 10) || (e == 29);
            if (e == 29) begin checks++; if (a_fr !== 1'b1) begin errors++; $display("FAIL b2b_first got %b want 1", a_fr); end end
            if (e == 59) begin checks++; if (a_fr !== 1'b1) begin errors++; $display("FAIL b2b_rearm got %b want 1", a_fr); end end
            if (e == 89) begin checks++; if (a_fr !== 1'b0) begin errors++; $display("FAIL b2b_spent got %b want 0", a_fr); end end
            if (e == 90) begin checks++; if (a_y !== 12'd1) begin errors++; $display("FAIL b2b_line1 got y=%0d want 1", a_y); end end
        end
        i_frame_end = 1'b0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            tick();
            i_frame_end = (e == 10);
            if (e == 16) i_genlock_en = 1'b0;
            if (e == 29) begin checks++; if (a_fr !== 1'b0) begin errors++; $display("FAIL en_clear_frame got %b want 0", a_fr); end end
            if (e == 30) begin checks++; if (a_y !== 12'd1) begin errors++; $display("FAIL en_clear_line got y=%0d want 1", a_y); end end
        end
        i_frame_end = 1'b0;
    endtask

    task automatic test_reset_midline();
        i_genlock_en = 1'b0;
        do_reset();
        for (int e = 1; e <= 40; e++) tick();
        checks++;
        if (a_x !== 12'd5 || a_y !== 12'd1) begin
            errors++; $display("FAIL midline_pos got x=%0d y=%0d want 5,1", a_x, a_y);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({a_ce, a_aclk, a_hs, a_vs, a_de, a_fr, a_lk} !== 7'b0 || {a_x, a_y, a_r, a_g, a_b} !== 48'h0) begin
            errors++; $display("FAIL midline_reset got ctl=%b x=%0d y=%0d r=%h", {a_ce, a_aclk, a_hs, a_vs, a_de, a_fr, a_lk}, a_x, a_y, a_r);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (a_ce !== 1'b1) begin errors++; $display("FAIL restart_ce got %b want 1", a_ce); end
        tick();
        checks++;
        if (a_x !== 12'd1 || a_y !== 12'd0 || a_de !== 1'b1 || a_r !== 8'hAA) begin
            errors++; $display("FAIL restart_pix0 got x=%0d y=%0d de=%b r=%h want 1,0,1,aa", a_x, a_y, a_de, a_r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_genlock_miss();
        test_lock();
        test_lock_window();
        test_back_to_back();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
